int_to_str: RTL and testbench



---
 rtl/int_to_str_pkg.sv | 31 +++
 rtl/int_to_str_if.sv | 24 ++
 rtl/int_to_str_bcd_dd_step.sv | 23 ++
 rtl/int_to_str.sv | 133 +++++++++++++
 tb/tb_int_to_str.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/int_to_str_pkg.sv
// Shared constants, FSM state type and digit helper for the int_to_str converter.
// Optional feature macro used by the converter: LEADING_ZERO_BLANK_EN.
package int_str_pkg;

    localparam int unsigned DIGITS     = 4;
    localparam int unsigned I_W        = 16;
    localparam int unsigned MAG_W      = 14;
    localparam int unsigned BCD_W      = 4 * DIGITS;
    localparam int unsigned SHREG_W    = BCD_W + MAG_W;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned CONV_ITERS = 14;
    localparam int unsigned MAX_MAG    = 9999;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ERR   = 8'h45;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        CONV = 2'd2,
        FMT  = 2'd3
    } state_e;

    // BCD nibble to its ASCII numeral.
    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/int_to_str_if.sv
// Conversion request/result bundle for int_to_str.
//   start, i                        : request (master -> converter)
//   busy, done, cint, csign, ovf    : status and result (converter -> master)
interface int_to_str_if import int_str_pkg::*; ();

    logic                          start;
    logic signed [I_W-1:0]         i;
    logic                          busy;
    logic                          done;
    logic        [8*DIGITS-1:0]    cint;
    logic        [7:0]             csign;
    logic                          ovf;

    modport master (
        output start, i,
        input  busy, done, cint, csign, ovf
    );

    modport slave (
        input  start, i,
        output busy, done, cint, csign, ovf
    );

endinterface

// File: rtl/int_to_str_bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift the
// {bcd, mag} register left by one.
//   din  : {bcd[15:0], mag[13:0]} before the iteration
//   dout : value after the iteration
module bcd_dd_step import int_str_pkg::*; (
    input  logic [SHREG_W-1:0] din,
    output logic [SHREG_W-1:0] dout
);

    logic [SHREG_W-1:0] adj;

    always_comb begin
        adj = din;
        for (int d = 0; d < DIGITS; d++) begin
            if (din[MAG_W + 4*d +: 4] >= 4'd5) begin
                adj[MAG_W + 4*d +: 4] = din[MAG_W + 4*d +: 4] + 4'd3;
            end
        end
        // Values never exceed 9999, so the bit shifted out is always zero.
        dout = adj << 1;
    end

endmodule

// File: rtl/int_to_str.sv
// Signed 16-bit integer to 4-digit ASCII decimal plus sign character.
// Iterative double-dabble behind a start/busy/done handshake; 16 cycles from
// the accepted start edge to the done pulse.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : int_to_str_if.slave (start, i in; busy, done, cint, csign, ovf out)
// Optional: define LEADING_ZERO_BLANK_EN to emit leading zero digits as spaces.
module int_to_str import int_str_pkg::*; (
    input  logic           clk,
    input  logic           reset,
    int_to_str_if.slave    bus
);

    localparam logic signed [I_W-1:0] MAX_S = I_W'(MAX_MAG);
    localparam logic signed [I_W-1:0] MIN_S = -MAX_S;

    state_e                  state, state_nx;

    logic signed [I_W-1:0]   i_q, i_d;
    logic                    neg_q, neg_d;
    logic                    rng_q, rng_d;
    logic [SHREG_W-1:0]      sh_q, sh_d, sh_step;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [8*DIGITS-1:0]     cint_d;
    logic [7:0]              csign_d;
    logic                    ovf_d, done_d, busy_d;
    logic signed [I_W-1:0]   abs_v;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    lz;
`endif

    bcd_dd_step u_step (
        .din  (sh_q),
        .dout (sh_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = ABS;
            ABS:  state_nx = CONV;
            CONV: if (cnt_q == CNT_W'(CONV_ITERS - 1)) state_nx = FMT;
            FMT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        i_d     = i_q;
        neg_d   = neg_q;
        rng_d   = rng_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        cint_d  = bus.cint;
        csign_d = bus.csign;
        ovf_d   = bus.ovf;
        done_d  = 1'b0;
        busy_d  = (state_nx != IDLE);
        abs_v   = i_q[I_W-1] ? -i_q : i_q;
`ifdef LEADING_ZERO_BLANK_EN
        lz      = 1'b1;
`endif
        case (state)
            IDLE: begin
                if (bus.start) i_d = bus.i;
            end
            ABS: begin
                neg_d = i_q[I_W-1];
                // Range check on the signed value so -32768 never needs negating.
                rng_d = (i_q > MAX_S) || (i_q < MIN_S);
                sh_d  = {{BCD_W{1'b0}}, (rng_d ? MAG_W'(0) : MAG_W'(abs_v))};
                cnt_d = '0;
            end
            CONV: begin
                sh_d  = sh_step;
                cnt_d = (cnt_q == CNT_W'(CONV_ITERS - 1)) ? '0 : cnt_q + CNT_W'(1);
            end
            FMT: begin
                for (int d = 0; d < DIGITS; d++) begin
                    cint_d[8*d +: 8] = ascii_digit(sh_q[MAG_W + 4*d +: 4]);
                end
`ifdef LEADING_ZERO_BLANK_EN
                // Blank from the most significant digit down; units always shown.
                for (int d = DIGITS - 1; d > 0; d--) begin
                    lz = lz && (sh_q[MAG_W + 4*d +: 4] == 4'd0);
                    if (lz) cint_d[8*d +: 8] = ASCII_SPACE;
                end
`endif
                if (rng_q) cint_d = {DIGITS{ASCII_ERR}};
                csign_d = neg_q ? ASCII_MINUS : ASCII_SPACE;
                ovf_d   = rng_q;
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_q       <= '0;
            neg_q     <= 1'b0;
            rng_q     <= 1'b0;
            sh_q      <= '0;
            cnt_q     <= '0;
            bus.cint  <= {DIGITS{ASCII_ZERO}};
            bus.csign <= ASCII_SPACE;
            bus.ovf   <= 1'b0;
            bus.done  <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            i_q       <= i_d;
            neg_q     <= neg_d;
            rng_q     <= rng_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            bus.cint  <= cint_d;
            bus.csign <= csign_d;
            bus.ovf   <= ovf_d;
            bus.done  <= done_d;
            bus.busy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_int_to_str.sv
// Directed, table-driven bench for int_to_str.
module tb_int_to_str;

    logic clk;
    logic reset;

    int_to_str_if bus ();

    int_to_str dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    typedef struct {
        logic signed [15:0] v;
        logic [31:0]        cint_z;
        logic [31:0]        cint_b;
        logic [7:0]         sign;
        logic               ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [31:0] z, input logic [31:0] b);
`ifdef LEADING_ZERO_BLANK_EN
        return b;
`else
        return z;
`endif
    endfunction

    // Text-side parser model: ASCII digits plus sign back to an integer.
    function automatic int parse(input logic [31:0] c, input logic [7:0] s);
        int val;
        val = 0;
        for (int d = 3; d >= 0; d--) begin
            logic [7:0] b;
            b = c[8*d +: 8];
            val = val * 10 + ((b == 8'h20) ? 0 : int'(b) - 48);
        end
        return (s == 8'h2D) ? -val : val;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse with value v; return latency to done and busy count.
    task automatic run_conv(input logic signed [15:0] v, output int lat, output int bcnt);
        bus.i     = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.i     = 16'sh5A5A;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, ndone;
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{16'sd1234,   32'h31323334, 32'h31323334, 8'h20, 1'b0};
        vecs[1] = '{-16'sd567,   32'h30353637, 32'h20353637, 8'h2D, 1'b0};
        vecs[2] = '{16'sd0,      32'h30303030, 32'h20202030, 8'h20, 1'b0};
        vecs[3] = '{16'sd10000,  32'h45454545, 32'h45454545, 8'h20, 1'b1};
        vecs[4] = '{-16'sd32768, 32'h45454545, 32'h45454545, 8'h2D, 1'b1};
        vecs[5] = '{16'sd9999,   32'h39393939, 32'h39393939, 8'h20, 1'b0};
        vecs[6] = '{-16'sd9999,  32'h39393939, 32'h39393939, 8'h2D, 1'b0};
        vecs[7] = '{16'sd42,     32'h30303432, 32'h20203432, 8'h20, 1'b0};
        vecs[8] = '{-16'sd10000, 32'h45454545, 32'h45454545, 8'h2D, 1'b1};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.i     = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("reset_cint",  bus.cint,          32'h30303030);
        chk("reset_csign", 32'(bus.csign),    32'h20);
        chk("reset_busy",  32'(bus.busy),     32'h0);
        chk("reset_done",  32'(bus.done),     32'h0);
        chk("reset_ovf",   32'(bus.ovf),      32'h0);

        for (int n = 0; n < 9; n++) begin
            run_conv(vecs[n].v, lat, bcnt);
            chk($sformatf("v%0d_latency", n), 32'(lat),  32'd16);
            chk($sformatf("v%0d_busy_cycles", n), 32'(bcnt), 32'd16);
            chk($sformatf("v%0d_busy_at_done", n), 32'(bus.busy), 32'h0);
            chk($sformatf("v%0d_cint", n),  bus.cint, pick(vecs[n].cint_z, vecs[n].cint_b));
            chk($sformatf("v%0d_csign", n), 32'(bus.csign), 32'(vecs[n].sign));
            chk($sformatf("v%0d_ovf", n),   32'(bus.ovf),   32'(vecs[n].ovf));
            tick();
            chk($sformatf("v%0d_done_pulse", n), 32'(bus.done), 32'h0);
            chk($sformatf("v%0d_hold_cint", n), bus.cint, pick(vecs[n].cint_z, vecs[n].cint_b));
        end

        // Start during a conversion is ignored.
        bus.i     = 16'sd1111;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.i     = 16'sd2222;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) ndone++;
            tick();
        end
        chk("ignore_done_count", 32'(ndone), 32'd1);
        chk("ignore_cint",       bus.cint,   32'h31313131);
        chk("ignore_busy",       32'(bus.busy), 32'h0);

        // Start held high across done restarts on the following edge.
        bus.i     = 16'sd300;
        bus.start = 1'b1;
        tick();
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        chk("b2b_first_latency", 32'(lat), 32'd16);
        chk("b2b_first_cint",    bus.cint, pick(32'h30333030, 32'h20333030));
        bus.i = 16'sd301;
        tick();
        bus.start = 1'b0;
        chk("b2b_busy_restart",  32'(bus.busy), 32'h1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        chk("b2b_second_latency", 32'(lat), 32'd16);
        chk("b2b_second_cint",    bus.cint, pick(32'h30333031, 32'h20333031));
        tick();

        // Reset mid-conversion aborts and restores reset values.
        bus.i     = 16'sd4321;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        chk("abort_cint",  bus.cint,       32'h30303030);
        chk("abort_csign", 32'(bus.csign), 32'h20);
        chk("abort_busy",  32'(bus.busy),  32'h0);
        chk("abort_ovf",   32'(bus.ovf),   32'h0);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done) ndone++;
            tick();
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        run_conv(16'sd4321, lat, bcnt);
        chk("rerun_latency", 32'(lat),       32'd16);
        chk("rerun_cint",    bus.cint,       32'h34333231);
        chk("rerun_csign",   32'(bus.csign), 32'h20);
        chk("roundtrip",     32'(parse(bus.cint, bus.csign)), 32'd4321);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
